aes_key_expander: RTL and testbench
===================================

# aes_key_expander

Sequential AES-128 key expansion engine that turns the 128-bit cipher key into the full 11-round-key schedule consumed by the decryption state driver. It sits directly upstream of the decryption controller and datapath. It is started by the same level-sensitive start flag, and it presents a 1408-bit `KeySchedule` bus plus a ready flag. Default build generates one 32-bit word per clock.

## Interface
Parameters:
- `NR`, default 10: number of AES rounds. Fixed at 10; any other value is unsupported.

Ports:
- `Clk`, input, 1: single clock. All state updates on the rising edge.
- `Reset`, input, 1: synchronous, active-high reset.
- `Start_h`, input, 1: level-sensitive start flag (reg[14]). Must stay high until `key_ready` is seen.
- `key_in`, input, 128: cipher key. Must be stable from `Start_h` rise through the LOAD cycle.
- `KeySchedule`, output, 1408: round key r at [128r+127:128r]. Within a round key, word w[4r] is the most-significant 32 bits. Round 0 (the cipher key) is at [127:0]; round 10 is at [1407:1280].
- `key_ready`, output, 1: high while in DONE; the schedule is complete and stable.
- `busy`, output, 1: high in LOAD and EXPAND.

## Operation
- FSM states: IDLE, LOAD, EXPAND, DONE.
- IDLE:
  - `Start_h`=1 → LOAD; otherwise stay.
- LOAD (1 cycle):
  - w0..w3 ← `key_in` (w0 = key_in[127:96]).
  - w4..w43 ← 0.
  - Word counter i ← 4.
  - Next state EXPAND.
- EXPAND, one word per cycle:
  - temp = w[i-1].
  - If i mod 4 = 0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/4], 24'h0}.
  - w[i] = w[i-4] ^ temp.
  - i increments. After writing w43 → DONE.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- DONE:
  - Schedule held.
  - `Start_h`=0 → IDLE.
  - `Start_h`=1 → stay (no restart until `Start_h` drops).
- `Start_h` dropping during LOAD/EXPAND is ignored: expansion completes, DONE lasts exactly 1 cycle, then IDLE.
- The schedule persists through IDLE. It is overwritten only by the next LOAD or by `Reset`.
- Reset at any cycle, including mid-expansion: next edge → IDLE, i=0, `KeySchedule`=0, `key_ready`=0, `busy`=0.
- Reset has priority over `Start_h` on the same edge.
- Counter i is 6 bits and never exceeds 43; no wrap-around path exists.

## Timing
- All outputs are registered. Reset values: `KeySchedule`=0, `key_ready`=0, `busy`=0.
- Edge E0 samples `Start_h`=1 in IDLE. The FSM is in LOAD during the cycle after E0.
- E1: key loaded. E2..E41: w4..w43 written.
- `key_ready` rises after edge E41, i.e. 41 cycles after E0 (word mode).
- Round key r is final once w[4r+3] is written (after edge E(4r+1)). Downstream must still wait for `key_ready`.
- `busy` is high from after E0 through the cycle before DONE.

## Configuration
- `AES_KEYEXP_ROUND_PER_CYCLE_EN` defined:
  - EXPAND computes one full round key (4 chained words, a single SubWord) per cycle.
  - The counter steps by round, 1..10.
  - `key_ready` rises after E11.
  - All other behaviour (states, reset, bit layout, DONE/IDLE handshake) is identical.
- Undefined: one word per cycle, as above (41-cycle latency).

## Structure
- Shared package `aes_pkg` holds:
  - FSM state enum.
  - Rcon table (10 × 8-bit constant array).
  - `AES_NK`=4, `AES_NWORDS`=44, `AES_SCHED_W`=1408.
- Sub-module `aes_sub_word`: combinational 4-byte S-box lookup (32-bit in/out). One instance in either build.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, `Start_h` held high → `key_ready` after 41 cycles:
  - w4=a0fafe17.
  - [1407:1280]=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - [127:0]=key.
- All-zero key → w4=62636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- `Reset` asserted at cycle 20 of EXPAND → next cycle IDLE, `KeySchedule`=0, `key_ready`=0. Restart with the FIPS key → correct schedule.
- `Start_h` pulsed for 2 cycles only → expansion completes, `key_ready` high exactly 1 cycle, then IDLE with the schedule retained.
- `Start_h` held after DONE with `key_in` changed → no re-expansion. Drop, then re-raise → new schedule, `key_ready` low during LOAD/EXPAND.
- With `AES_KEYEXP_ROUND_PER_CYCLE_EN` → same FIPS results, `key_ready` after 11 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 key expander: FSM states, schedule
// geometry and the round-constant table.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND,
    ST_DONE
  } aes_state_e;

  localparam int AES_NK      = 4;     // words per round key
  localparam int AES_NWORDS  = 44;    // w0..w43
  localparam int AES_SCHED_W = 1408;  // 11 round keys x 128 bits

  // Rcon[1..10], stored at index 0..9.
  localparam logic [7:0] AES_RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Cyclic left rotation by one byte.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Handshake and data bus between the key expander and its controller.
interface aes_key_expander_if;
  import aes_pkg::*;

  logic                   Start_h;
  logic [127:0]           key_in;
  logic [AES_SCHED_W-1:0] KeySchedule;
  logic                   key_ready;
  logic                   busy;

  // Controller side: starts expansion and consumes the schedule.
  modport master (
    output Start_h, key_in,
    input  KeySchedule, key_ready, busy
  );

  // Expander side.
  modport slave (
    input  Start_h, key_in,
    output KeySchedule, key_ready, busy
  );
endinterface

// File: rtl/aes_sub_word.sv
// Combinational AES SubWord: the forward S-box applied to each byte of a word.
module aes_sub_word (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign word_o = {SBOX[word_i[31:24]], SBOX[word_i[23:16]],
                   SBOX[word_i[15:8]],  SBOX[word_i[7:0]]};

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128 key expander producing the 11 round keys on a 1408-bit bus.
// Default build writes one schedule word per clock (key_ready 41 cycles after
// the start edge). Defining AES_KEYEXP_ROUND_PER_CYCLE_EN writes a whole round
// key per clock (key_ready 11 cycles after the start edge).
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic               Clk,
  input  logic               Reset,
  aes_key_expander_if.slave  kif
);

`ifdef AES_KEYEXP_ROUND_PER_CYCLE_EN
  localparam logic [5:0] FIRST_I = 6'd1;         // counter holds the round index
  localparam logic [5:0] LAST_I  = 6'(NR);
`else
  localparam logic [5:0] FIRST_I = 6'(AES_NK);   // counter holds the word index
  localparam logic [5:0] LAST_I  = 6'(AES_NK * (NR + 1) - 1);
`endif

  aes_state_e             state_q;
  logic [5:0]             i_q;
  logic [31:0]            w_q [AES_NWORDS];
  logic                   key_ready_q;
  logic                   busy_q;

  logic [31:0]            sub_in;
  logic [31:0]            sub_out;
  logic [AES_SCHED_W-1:0] sched;

  aes_sub_word u_sub_word (
    .word_i (sub_in),
    .word_o (sub_out)
  );

`ifdef AES_KEYEXP_ROUND_PER_CYCLE_EN
  logic [5:0]  base_idx;
  logic [5:0]  prev_idx;
  logic [31:0] round_d [AES_NK];

  // Next round key: four chained words sharing one SubWord of the last word.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    base_idx   = {i_q[3:0], 2'b00};
    prev_idx   = base_idx - 6'd4;
    sub_in     = rot_word(w_q[prev_idx + 6'd3]);
    round_d[0] = w_q[prev_idx] ^ sub_out ^ {AES_RCON[i_q[3:0] - 4'd1], 24'h0};
    round_d[1] = w_q[prev_idx + 6'd1] ^ round_d[0];
    round_d[2] = w_q[prev_idx + 6'd2] ^ round_d[1];
    round_d[3] = w_q[prev_idx + 6'd3] ^ round_d[2];
  end
`else
  logic [31:0] prev_w;
  logic [31:0] temp;
  logic [31:0] word_d;

  // Next schedule word w[i] from w[i-1] and w[i-4].
  always_comb begin
    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    prev_w = w_q[i_q - 6'd1];
    sub_in = rot_word(prev_w);
    temp   = (i_q[1:0] == 2'b00) ? (sub_out ^ {AES_RCON[i_q[5:2] - 4'd1], 24'h0})
                                 : prev_w;
    word_d = w_q[i_q - 6'd4] ^ temp;
  end
`endif

  // FSM, word store and registered status flags.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses <= so every register sees pre-edge values.
    if (Reset) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      key_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      // NOTE: the word store is reset element by element because the schedule must read zero after Reset.
      for (int k = 0; k < AES_NWORDS; k++) w_q[k] <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (kif.Start_h) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          for (int k = AES_NK; k < AES_NWORDS; k++) w_q[k] <= '0;
          w_q[0]  <= kif.key_in[127:96];
          w_q[1]  <= kif.key_in[95:64];
          w_q[2]  <= kif.key_in[63:32];
          w_q[3]  <= kif.key_in[31:0];
          i_q     <= FIRST_I;
          state_q <= ST_EXPAND;
        end
        ST_EXPAND: begin
`ifdef AES_KEYEXP_ROUND_PER_CYCLE_EN
          for (int j = 0; j < AES_NK; j++) w_q[base_idx + 6'(j)] <= round_d[j];
`else
          w_q[i_q] <= word_d;
`endif
          if (i_q == LAST_I) begin
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            key_ready_q <= 1'b1;
          end else begin
            i_q <= i_q + 6'd1;
          end
        end
        ST_DONE: begin
          // Hold until the start flag drops so a held flag cannot retrigger.
          if (!kif.Start_h) begin
            state_q     <= ST_IDLE;
            key_ready_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Pack words: round r at [128r+127:128r], w[4r] in the top 32 bits.
  always_comb begin
    sched = '0;
    for (int k = 0; k < AES_NWORDS; k++)
      sched[128 * (k / 4) + 32 * (3 - (k % 4)) +: 32] = w_q[k];
  end

  assign kif.KeySchedule = sched;
  assign kif.key_ready   = key_ready_q;
  assign kif.busy        = busy_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: known FIPS-197 vectors plus random
// keys against a model that derives the S-box from GF(2^8) arithmetic.
module tb_aes_key_expander;

`ifdef AES_KEYEXP_ROUND_PER_CYCLE_EN
  localparam int EXP_LAT = 11;
`else
  localparam int EXP_LAT = 41;
`endif

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  aes_key_expander_if kif ();

  aes_key_expander #(.NR(10)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .kif   (kif.slave)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [7:0] sbox_t [256];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (a != 0 && gf_mul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      sbox_t[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] model_schedule(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [1407:0] s;
    for (int k = 0; k < 4; k++) w[k] = key[127 - 32 * k -: 32];
    for (int k = 4; k < 44; k++) begin
      t = w[k - 1];
      if (k % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t ^= {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[k] = w[k - 4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      s[128 * r +: 128] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    return s;
  endfunction

  function automatic int first_bad_round(input logic [1407:0] a, input logic [1407:0] b);
    for (int r = 0; r < 11; r++)
      if (a[128 * r +: 128] !== b[128 * r +: 128]) return r;
    return 0;
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers ----------------
  // Raise Start_h with key; drop it after `hold` edges (0 = keep high).
  // latency = edges after E0 until key_ready, -1 on timeout.
  // flag_bad = busy/key_ready wrong while expansion was in progress.
  task automatic run_expand(input logic [127:0] key, input int hold,
                            output int latency, output bit flag_bad);
    latency  = -1;
    flag_bad = 1'b0;
    @(negedge Clk);
    kif.key_in  = key;
    kif.Start_h = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge Clk);
      if (n == hold) kif.Start_h = 1'b0;
      if (kif.key_ready) begin
        latency = n - 1;
        if (kif.busy !== 1'b0) flag_bad = 1'b1;
        break;
      end
      if (kif.busy !== 1'b1) flag_bad = 1'b1;
    end
  endtask

  task automatic release_start();
    @(negedge Clk);
    kif.Start_h = 1'b0;
    @(negedge Clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset       = 1'b1;
    kif.Start_h = 1'b1;   // reset must win over start
    kif.key_in  = FIPS_KEY;
    repeat (2) @(negedge Clk);
    chk_cnt++;
    if (kif.KeySchedule !== '0) $display("FAIL reset_sched: got nonzero schedule, want 0");
    else pass_cnt++;
    chk_cnt++;
    if (kif.key_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", kif.key_ready);
    else pass_cnt++;
    chk_cnt++;
    if (kif.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", kif.busy);
    else pass_cnt++;
    kif.Start_h = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_fips();
    int lat; bit bad;
    logic [1407:0] exp_s = model_schedule(FIPS_KEY);
    run_expand(FIPS_KEY, 0, lat, bad);
    chk_cnt++;
    if (lat != EXP_LAT) $display("FAIL fips_latency: got %0d want %0d", lat, EXP_LAT);
    else pass_cnt++;
    chk_cnt++;
    if (bad) $display("FAIL fips_busy_flags: busy/key_ready wrong during expansion, want busy=1 ready=0");
    else pass_cnt++;
    chk_cnt++;
    if (kif.KeySchedule[255:224] !== 32'ha0fafe17)
      $display("FAIL fips_w4: got %h want a0fafe17", kif.KeySchedule[255:224]);
    else pass_cnt++;
    chk_cnt++;
    if (kif.KeySchedule[1407:1280] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6)
      $display("FAIL fips_round10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", kif.KeySchedule[1407:1280]);
    else pass_cnt++;
    chk_cnt++;
    if (kif.KeySchedule[127:0] !== FIPS_KEY)
      $display("FAIL fips_round0: got %h want %h", kif.KeySchedule[127:0], FIPS_KEY);
    else pass_cnt++;
    chk_cnt++;
    if (kif.KeySchedule !== exp_s) begin
      int r = first_bad_round(kif.KeySchedule, exp_s);
      $display("FAIL fips_model round %0d: got %h want %h", r, kif.KeySchedule[128 * r +: 128], exp_s[128 * r +: 128]);
    end else pass_cnt++;
    release_start();
  endtask

  task automatic test_zero_key();
    int lat; bit bad;
    run_expand(128'h0, 0, lat, bad);
    chk_cnt++;
    if (kif.KeySchedule[255:224] !== 32'h62636363)
      $display("FAIL zero_w4: got %h want 62636363", kif.KeySchedule[255:224]);
    else pass_cnt++;
    chk_cnt++;
    if (kif.KeySchedule[1407:1280] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e)
      $display("FAIL zero_round10: got %h want b4ef5bcb3e92e21123e951cf6f8f188e", kif.KeySchedule[1407:1280]);
    else pass_cnt++;
    release_start();
  endtask

  task automatic test_reset_mid();
    int lat; bit bad;
    logic [1407:0] exp_s = model_schedule(FIPS_KEY);
    @(negedge Clk);
    kif.key_in  = 128'h000102030405060708090a0b0c0d0e0f;
    kif.Start_h = 1'b1;
    repeat (21) @(negedge Clk);   // after E20: EXPAND cycle 20
    Reset = 1'b1;
    @(negedge Clk);
    chk_cnt++;
    if (kif.KeySchedule !== '0) $display("FAIL midreset_sched: got nonzero schedule, want 0");
    else pass_cnt++;
    chk_cnt++;
    if (kif.key_ready !== 1'b0 || kif.busy !== 1'b0)
      $display("FAIL midreset_flags: got ready=%b busy=%b want 0 0", kif.key_ready, kif.busy);
    else pass_cnt++;
    kif.Start_h = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    run_expand(FIPS_KEY, 0, lat, bad);
    chk_cnt++;
    if (lat != EXP_LAT || kif.KeySchedule !== exp_s)
      $display("FAIL midreset_restart: latency %0d want %0d, round10 %h want %h",
               lat, EXP_LAT, kif.KeySchedule[1407:1280], exp_s[1407:1280]);
    else pass_cnt++;
    release_start();
  endtask

  task automatic test_pulse_start();
    int lat; bit bad;
    logic [127:0]  key   = rand_key();
    logic [1407:0] exp_s = model_schedule(key);
    run_expand(key, 2, lat, bad);
    chk_cnt++;
    if (lat != EXP_LAT) $display("FAIL pulse_latency: got %0d want %0d", lat, EXP_LAT);
    else pass_cnt++;
    @(negedge Clk);
    chk_cnt++;
    if (kif.key_ready !== 1'b0 || kif.busy !== 1'b0)
      $display("FAIL pulse_done_one_cycle: got ready=%b busy=%b want 0 0", kif.key_ready, kif.busy);
    else pass_cnt++;
    repeat (5) @(negedge Clk);
    chk_cnt++;
    if (kif.KeySchedule !== exp_s) begin
      int r = first_bad_round(kif.KeySchedule, exp_s);
      $display("FAIL pulse_retained round %0d: got %h want %h", r, kif.KeySchedule[128 * r +: 128], exp_s[128 * r +: 128]);
    end else pass_cnt++;
  endtask

  task automatic test_hold_after_done();
    int lat; bit bad;
    logic [127:0] key_a = rand_key();
    logic [127:0] key_b = rand_key();
    logic [1407:0] exp_a = model_schedule(key_a);
    logic [1407:0] exp_b = model_schedule(key_b);
    run_expand(key_a, 0, lat, bad);
    kif.key_in = key_b;
    repeat (20) @(negedge Clk);
    chk_cnt++;
    if (kif.key_ready !== 1'b1 || kif.busy !== 1'b0)
      $display("FAIL hold_no_restart_flags: got ready=%b busy=%b want 1 0", kif.key_ready, kif.busy);
    else pass_cnt++;
    chk_cnt++;
    if (kif.KeySchedule !== exp_a)
      $display("FAIL hold_no_restart_sched: round10 %h want %h", kif.KeySchedule[1407:1280], exp_a[1407:1280]);
    else pass_cnt++;
    kif.Start_h = 1'b0;
    @(negedge Clk);
    chk_cnt++;
    if (kif.key_ready !== 1'b0) $display("FAIL hold_drop_ready: got %b want 0", kif.key_ready);
    else pass_cnt++;
    run_expand(key_b, 0, lat, bad);
    chk_cnt++;
    if (bad || lat != EXP_LAT)
      $display("FAIL rerun_flags: latency %0d want %0d, bad_flags=%0d want 0", lat, EXP_LAT, bad);
    else pass_cnt++;
    chk_cnt++;
    if (kif.KeySchedule !== exp_b) begin
      int r = first_bad_round(kif.KeySchedule, exp_b);
      $display("FAIL rerun_sched round %0d: got %h want %h", r, kif.KeySchedule[128 * r +: 128], exp_b[128 * r +: 128]);
    end else pass_cnt++;
    release_start();
  endtask

  task automatic test_random_keys();
    for (int t = 0; t < 4; t++) begin
      int lat; bit bad;
      logic [127:0]  key   = rand_key();
      logic [1407:0] exp_s = model_schedule(key);
      run_expand(key, 0, lat, bad);
      chk_cnt++;
      if (kif.KeySchedule !== exp_s || lat != EXP_LAT) begin
        int r = first_bad_round(kif.KeySchedule, exp_s);
        $display("FAIL random_%0d key %h: latency %0d want %0d, round %0d got %h want %h",
                 t, key, lat, EXP_LAT, r, kif.KeySchedule[128 * r +: 128], exp_s[128 * r +: 128]);
      end else pass_cnt++;
      release_start();
    end
  endtask

  initial begin
    Reset       = 1'b1;
    kif.Start_h = 1'b0;
    kif.key_in  = '0;
    build_sbox();
    test_reset();
    test_fips();
    test_zero_key();
    test_reset_mid();
    test_pulse_start();
    test_hold_after_done();
    test_random_keys();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
